sobol_sng_frame: RTL and testbench

Frame-based stochastic number generator that sits directly downstream of the 1-D Sobol RNG. It accepts one binary operand per frame through a valid/ready handshake and drives the RNG `enable` for exactly 2^INWD advancing cycles. Each cycle it compares the operand against the RNG word and emits one bitstream bit. Its output bitstream feeds the stochastic multiplier datapath.

---
 rtl/sobol_sng_frame_if.sv | 40 ++++
 rtl/sobol_sng_frame.sv | 118 +++++++++++
 tb/tb_sobol_sng_frame.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobol_sng_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : sobol_sng_frame_if
// Purpose  : Bundles the operand handshake, RNG hookup and bitstream outputs
//            of sobol_sng_frame into one interface.
// Ports    : (interface members)
//   inValid/inReady/inData  operand valid/ready handshake
//   hold                    frame pause request
//   rngEnable/rngIn         Sobol RNG enable and sequence word
//   bitOut/bitValid         stochastic bit and its qualifier
//   frameDone               pulse on the last bit of a frame
//   onesCnt                 ones counted in the current/last frame
// Modports : master = operand source + RNG side, slave = the generator
// Revision : 1.0 - initial release
// ============================================================================
interface sobol_sng_frame_if #(
  parameter int INWD = 8
);
  logic            inValid;
  logic            inReady;
  logic [INWD-1:0] inData;
  logic            hold;
  logic            rngEnable;
  logic [INWD-1:0] rngIn;
  logic            bitOut;
  logic            bitValid;
  logic            frameDone;
  logic [INWD:0]   onesCnt;

  modport master (
    output inValid, inData, hold, rngIn,
    input  inReady, rngEnable, bitOut, bitValid, frameDone, onesCnt
  );

  modport slave (
    input  inValid, inData, hold, rngIn,
    output inReady, rngEnable, bitOut, bitValid, frameDone, onesCnt
  );
endinterface
`default_nettype wire

// File: rtl/sobol_sng_frame.sv
`default_nettype none
// ============================================================================
// Module   : sobol_sng_frame
// Purpose  : Frame-based stochastic number generator placed after a 1-D
//            Sobol RNG. Accepts one operand per frame, advances the RNG for
//            2^INWD cycles and emits bitOut = (operand > rngIn) each cycle.
// Ports    :
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset (shared with the RNG)
//   bus   sobol_sng_frame_if.slave - handshake, RNG hookup, bitstream
// Options  : SNG_ONES_CNT_EN - when defined, compiles in the per-frame ones
//            counter driven on bus.onesCnt; otherwise onesCnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sobol_sng_frame #(
  parameter int INWD = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  sobol_sng_frame_if.slave      bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [INWD-1:0] FC_ONE = {{(INWD-1){1'b0}}, 1'b1};

  state_t          state;
  logic [INWD-1:0] opnd;
  logic [INWD-1:0] frame_cnt;
  logic            bit_out;
  logic            bit_valid;
  logic            frame_done;

  logic            accept;
  logic            advance;
  logic            cmp;
  logic            last;

  assign accept  = (state == IDLE) && bus.inValid;
  assign advance = (state == RUN) && !bus.hold;
  assign cmp     = (opnd > bus.rngIn);
  // frame_cnt counts advancing cycles already done; all-ones marks the last
  assign last    = (frame_cnt == {INWD{1'b1}});

  assign bus.inReady   = (state == IDLE);
  // Combinational so a hold pauses the RNG in the same cycle it is raised
  assign bus.rngEnable = advance;
  assign bus.bitOut    = bit_out;
  assign bus.bitValid  = bit_valid;
  assign bus.frameDone = frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      opnd       <= '0;
      frame_cnt  <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_valid  <= 1'b0;
          frame_done <= 1'b0;
          if (accept) begin
            opnd      <= bus.inData;
            frame_cnt <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (!bus.hold) begin
            bit_out    <= cmp;
            bit_valid  <= 1'b1;
            frame_cnt  <= frame_cnt + FC_ONE;  // wraps to 0 after the last bit
            frame_done <= last;
            if (last) begin
              state <= IDLE;
            end
          end else begin
            // Paused: bitOut keeps its last value, counters frozen
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SNG_ONES_CNT_EN
  localparam logic [INWD:0] OC_ZERO = '0;

  logic [INWD:0] ones_cnt;

  // Cleared on handshake, holds the final count in IDLE until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= OC_ZERO;
    end else if (accept) begin
      ones_cnt <= OC_ZERO;
    end else if (advance) begin
      ones_cnt <= ones_cnt + {{INWD{1'b0}}, cmp};
    end
  end

  assign bus.onesCnt = ones_cnt;
`else
  assign bus.onesCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobol_sng_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobol_sng_frame
// Purpose  : Self-checking bench for sobol_sng_frame with a behavioural
//            1-D Sobol RNG attached. Every bit is compared with
//            (operand > sobol(k)), k counting RNG advances since reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobol_sng_frame;

  localparam int INWD = 8;
  localparam int FLEN = 1 << INWD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sobol_sng_frame_if #(.INWD(INWD)) bus ();

  sobol_sng_frame #(.INWD(INWD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // n-th point of the 1-D Sobol sequence: bit-reversed Gray code of n
  function automatic logic [INWD-1:0] sobol(input int n);
    logic [INWD-1:0] b;
    logic [INWD-1:0] g;
    logic [INWD-1:0] r;
    b = n[INWD-1:0];
    g = b ^ (b >> 1);
    for (int i = 0; i < INWD; i++) r[INWD-1-i] = g[i];
    return r;
  endfunction

  // RNG: registered sequence word, advances one cycle after enable
  int rng_idx;
  always_ff @(posedge clk) begin
    if (rst) rng_idx <= 0;
    else if (bus.rngEnable) rng_idx <= rng_idx + 1;
  end
  assign bus.rngIn = sobol(rng_idx);

  function automatic int exp_ones(input int n);
`ifdef SNG_ONES_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int ref_idx = 0;           // RNG advances the model expects so far
  logic [INWD-1:0] m_opnd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_inReady"},   bus.inReady,   1);
    chk({tag, "_rngEnable"}, bus.rngEnable, 0);
    chk({tag, "_bitOut"},    bus.bitOut,    0);
    chk({tag, "_bitValid"},  bus.bitValid,  0);
    chk({tag, "_frameDone"}, bus.frameDone, 0);
    chk({tag, "_onesCnt"},   bus.onesCnt,   0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.inValid = 1'b0;
    bus.hold = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    ref_idx = 0;
  endtask

  // Runs one frame starting from IDLE. Hold covers RUN cycles
  // [hold_at, hold_at+hold_len). abort_at >= 0 pulses rst after that many bits.
  task automatic frame(input logic [INWD-1:0] d, input int hold_at, input int hold_len,
                       input bit keep_valid, input logic [INWD-1:0] next_d,
                       input int abort_at, output logic [3:0] first4, output int hs);
    int bits;
    int ones;
    int run_cyc;
    bit hold_now;
    bit done;
    logic exp_bit;
    first4 = 4'b0000;
    chk("idle_inReady", bus.inReady, 1);
    bus.inValid = 1'b1;
    bus.inData = d;
    tick();
    hs = cyc_cnt;
    m_opnd = d;
    if (keep_valid) bus.inData = next_d;
    else begin
      bus.inValid = 1'($urandom_range(0, 1));
      bus.inData = INWD'($urandom);
    end
    bits = 0;
    ones = 0;
    run_cyc = 0;
    done = 1'b0;
    while (!done && run_cyc < 4 * FLEN) begin
      run_cyc++;
      hold_now = (run_cyc >= hold_at) && (run_cyc < hold_at + hold_len);
      bus.hold = hold_now;
      #1;
      chk("run_inReady", bus.inReady, 0);
      chk("run_rngEnable", bus.rngEnable, !hold_now);
      if (abort_at >= 0 && bits == abort_at) begin
        rst = 1'b1;
        bus.hold = 1'b0;
        bus.inValid = 1'b0;
        tick();
        rst = 1'b0;
        chk_reset_vals("abort");
        ref_idx = 0;
        return;
      end
      tick();
      chk("bitValid", bus.bitValid, !hold_now);
      if (!hold_now) begin
        exp_bit = (m_opnd > sobol(ref_idx));
        ref_idx++;
        chk("bitOut", bus.bitOut, exp_bit);
        if (bits < 4) first4[3-bits] = bus.bitOut;
        ones += int'(bus.bitOut);
        bits++;
      end
      chk("frameDone", bus.frameDone, (bits == FLEN) && !hold_now);
      if (bits == FLEN) done = 1'b1;
    end
    chk("frame_completed", done, 1);
    chk("done_latency", run_cyc, FLEN + hold_len);
    chk("done_inReady", bus.inReady, 1);
    chk("frame_ones", ones, d);
    chk("onesCnt", bus.onesCnt, exp_ones(d));
    bus.hold = 1'b0;
    bus.inValid = keep_valid;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] f4;
    int hs_a;
    int hs_b;
    logic [INWD-1:0] rd;
    bus.inValid = 1'b0;
    bus.inData = '0;
    bus.hold = 1'b0;
    tick();
    do_reset();

    // First frame after reset: full scale, single zero at RNG value 255
    frame(8'd255, 0, 0, 1'b0, 8'd0, -1, f4, hs_a);
    chk("first4_255", f4, 4'b1111);

    // Zero operand: all zeros
    frame(8'd0, 0, 0, 1'b0, 8'd0, -1, f4, hs_a);
    chk("first4_0", f4, 4'b0000);

    // Fresh reset, half scale
    do_reset();
    frame(8'd128, 0, 0, 1'b0, 8'd0, -1, f4, hs_a);
    chk("first4_128", f4, 4'b1001);

    // Hold for 10 cycles mid-frame
    frame(8'd77, 50, 10, 1'b0, 8'd0, -1, f4, hs_a);

    // inValid held high: back-to-back frames every 2^INWD+1 cycles
    frame(8'd40, 0, 0, 1'b1, 8'd200, -1, f4, hs_a);
    frame(8'd200, 0, 0, 1'b0, 8'd0, -1, f4, hs_b);
    chk("frame_period", hs_b - hs_a, FLEN + 1);

    // onesCnt holds in IDLE
    tick();
    tick();
    chk("idle_hold_onesCnt", bus.onesCnt, exp_ones(200));
    chk("idle_bitValid", bus.bitValid, 0);
    chk("idle_frameDone", bus.frameDone, 0);

    // Reset after bit 100 aborts the frame; next frame starts clean
    rd = INWD'($urandom);
    frame(rd, 0, 0, 1'b0, 8'd0, 100, f4, hs_a);
    tick();
    chk("post_abort_frameDone", bus.frameDone, 0);
    frame(8'd33, 0, 0, 1'b0, 8'd0, -1, f4, hs_a);

    // Randomized operands and hold windows
    for (int k = 0; k < 3; k++) begin
      rd = INWD'($urandom);
      frame(rd, int'($urandom_range(1, 250)), int'($urandom_range(1, 20)),
            1'b0, 8'd0, -1, f4, hs_a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
